bin2bcd: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Accepts an N-bit unsigned binary value on a start strobe.
- Produces four packed BCD digits (thousands..units) after a fixed multi-cycle latency, then pulses done.
- Sits between arithmetic/count logic and display drivers, e.g. seven-segment digit muxes.

---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bcd_add3.sv | 16 +
 rtl/bin2bcd.sv | 105 ++++++++++
 tb/tb_bin2bcd.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_N      = 13;
    localparam int SCR_W      = BCD_W * NUM_DIGITS;
    localparam int CNT_W      = $clog2(MAX_N + 1);

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction nibble: add 3 when the digit is 5 or more.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] nib,
    output logic [BCD_W-1:0] adj
);

    always_comb begin
        adj = nib;
        if (nib >= BCD_W'(5)) begin
            adj = nib + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter; one input bit per SHIFT cycle,
// four registered digits and a one-cycle done pulse on completion.
module bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int N = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     bin,
    output logic [BCD_W-1:0] bcd3,
    output logic [BCD_W-1:0] bcd2,
    output logic [BCD_W-1:0] bcd1,
    output logic [BCD_W-1:0] bcd0,
    output logic             done
);

    state_t             state_q;
    state_t             state_d;
    logic [N-1:0]       bin_q;
    logic [SCR_W-1:0]   scr_q;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               load;
    logic               shift;
    logic               finish;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .nib (scr_q[i*BCD_W +: BCD_W]),
            .adj (adj[i*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Last bit goes in on this edge
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            IDLE:    load   = start;
            SHIFT:   shift  = 1'b1;
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            bin_q <= bin;
            scr_q <= '0;
            cnt_q <= CNT_W'(N);
        end else if (shift) begin
            {scr_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            bcd3 <= '0;
            bcd2 <= '0;
            bcd1 <= '0;
            bcd0 <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                {bcd3, bcd2, bcd1, bcd0} <= scr_q;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd.sv
// Scoreboard bench for bin2bcd: N=7 and N=13 instances, directed vectors.
module tb_bin2bcd;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start7 = 1'b0;
    logic [6:0]  bin7 = '0;
    logic        start13 = 1'b0;
    logic [12:0] bin13 = '0;
    logic [3:0]  d7_3, d7_2, d7_1, d7_0;
    logic [3:0]  d13_3, d13_2, d13_1, d13_0;
    logic        done7, done13;

    exp_t        sb7[$];
    exp_t        sb13[$];
    logic [15:0] held7 = '0;
    logic [15:0] held13 = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd #(.N(7)) u7 (
        .clk   (clk),
        .rst   (rst),
        .start (start7),
        .bin   (bin7),
        .bcd3  (d7_3),
        .bcd2  (d7_2),
        .bcd1  (d7_1),
        .bcd0  (d7_0),
        .done  (done7)
    );

    bin2bcd #(.N(13)) u13 (
        .clk   (clk),
        .rst   (rst),
        .start (start13),
        .bin   (bin13),
        .bcd3  (d13_3),
        .bcd2  (d13_2),
        .bcd1  (d13_1),
        .bcd0  (d13_0),
        .done  (done13)
    );

    // Monitor for the N=7 instance
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] dig;
        dig = {d7_3, d7_2, d7_1, d7_0};
        checks++;
        if (rst) begin
            sb7.delete();
            held7 = '0;
            if (dig !== 16'h0 || done7 !== 1'b0) begin
                errors++;
                $display("FAIL n7_reset: got %h done %b, want 0000 done 0",
                         dig, done7);
            end
        end else if (done7) begin
            if (sb7.size() == 0) begin
                errors++;
                $display("FAIL n7_spurious_done: got %h at cyc %0d, want no done",
                         dig, cyc);
            end else begin
                e = sb7.pop_front();
                held7 = e.val;
                if (dig !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL n7_result: got %h at cyc %0d, want %h at cyc %0d",
                             dig, cyc, e.val, e.cyc);
                end
            end
        end else if (dig !== held7) begin
            errors++;
            $display("FAIL n7_hold: got %h, want %h", dig, held7);
        end
    end

    // Monitor for the N=13 instance
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] dig;
        dig = {d13_3, d13_2, d13_1, d13_0};
        checks++;
        if (rst) begin
            sb13.delete();
            held13 = '0;
            if (dig !== 16'h0 || done13 !== 1'b0) begin
                errors++;
                $display("FAIL n13_reset: got %h done %b, want 0000 done 0",
                         dig, done13);
            end
        end else if (done13) begin
            if (sb13.size() == 0) begin
                errors++;
                $display("FAIL n13_spurious_done: got %h at cyc %0d, want no done",
                         dig, cyc);
            end else begin
                e = sb13.pop_front();
                held13 = e.val;
                if (dig !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL n13_result: got %h at cyc %0d, want %h at cyc %0d",
                             dig, cyc, e.val, e.cyc);
                end
            end
        end else if (dig !== held13) begin
            errors++;
            $display("FAIL n13_hold: got %h, want %h", dig, held13);
        end
    end

    // Entered and left 2 time units after a rising edge
    task automatic go7(input logic [6:0] b, input logic [15:0] e);
        start7 = 1'b1;
        bin7   = b;
        @(posedge clk);
        #1;
        sb7.push_back('{val: e, cyc: cyc + 8});
        #1;
        start7 = 1'b0;
    endtask

    task automatic go13(input logic [12:0] b, input logic [15:0] e);
        start13 = 1'b1;
        bin13   = b;
        @(posedge clk);
        #1;
        sb13.push_back('{val: e, cyc: cyc + 14});
        #1;
        start13 = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((sb7.size() != 0 || sb13.size() != 0) && i < 200) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (sb7.size() != 0 || sb13.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d/%0d pending, want 0/0",
                     name, sb7.size(), sb13.size());
            sb7.delete();
            sb13.delete();
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        go7(7'd7, 16'h0007);    drain("b7");
        go7(7'd53, 16'h0053);   drain("b53");
        go7(7'd99, 16'h0099);   drain("b99");
        go7(7'd120, 16'h0120);  drain("b120");
        go7(7'd127, 16'h0127);  drain("b127");
        go7(7'd0, 16'h0000);    drain("b0");

        // A second start mid-conversion must be dropped
        go7(7'd120, 16'h0120);
        repeat (2) @(posedge clk);
        #2;
        start7 = 1'b1;
        bin7   = 7'd33;
        @(posedge clk);
        #2;
        start7 = 1'b0;
        drain("ignore");

        // Reset mid-conversion cancels the result
        go7(7'd99, 16'h0099);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        go7(7'd45, 16'h0045);   drain("b45");

        go13(13'd8191, 16'h8191); drain("b8191");

        // Held start: back-to-back every N+2 cycles
        start13 = 1'b1;
        bin13   = 13'd1000;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sb13.push_back('{val: 16'h1000, cyc: cyc + 14 + 15 * k});
        end
        repeat (30) @(posedge clk);
        #2;
        start13 = 1'b0;
        drain("held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
